// File: rtl/comm_arb_pkg.sv
// Shared types and constants for the command-master arbiter.
package comm_arb_pkg;

  // Transaction phases of the arbiter FSM.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_SENT = 2'd2,
    WAIT_RESP = 2'd3
  } arb_state_t;

  // Byte returned to the owner when the master never answers.
  localparam logic [7:0] TIMEOUT_RSP = 8'h00;

  // Width needed to hold values 0..n-1, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/comm_arbiter_if.sv
// Bundle of requester-side and command-master-side signals of comm_arbiter.
//
// Handshakes: req_vld[i] is held by requester i until it sees the one-cycle
// req_gnt[i]; rsp_vld[i] is a one-cycle pulse qualifying rsp_data/rsp_err;
// send_cmd is a one-cycle pulse answered later by cmd_sent; resp_rdy is held
// by the master until the arbiter pulses clr_resp_rdy, which it does in the
// same cycle it samples resp.
//
// The master modport is the arbiter's view; slave is the view of the
// requesters plus the command master that surround it.
interface comm_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_vld;
  logic [NUM_REQ*8-1:0]  req_cmd;
  logic [NUM_REQ*16-1:0] req_data;
  logic [NUM_REQ-1:0]    req_gnt;
  logic [NUM_REQ-1:0]    rsp_vld;
  logic [7:0]            rsp_data;
  logic                  rsp_err;
  logic                  busy;
  logic                  send_cmd;
  logic [7:0]            cmd;
  logic [15:0]           data;
  logic                  cmd_sent;
  logic [7:0]            resp;
  logic                  resp_rdy;
  logic                  clr_resp_rdy;

  modport master (
    input  req_vld, req_cmd, req_data, cmd_sent, resp, resp_rdy,
    output req_gnt, rsp_vld, rsp_data, rsp_err, busy, send_cmd, cmd, data,
           clr_resp_rdy
  );

  modport slave (
    output req_vld, req_cmd, req_data, cmd_sent, resp, resp_rdy,
    input  req_gnt, rsp_vld, rsp_data, rsp_err, busy, send_cmd, cmd, data,
           clr_resp_rdy
  );
endinterface

// File: rtl/comm_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N. The pointer register lives in the parent.
module rr_arbiter
  import comm_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          req,
  input  logic [idx_w(N)-1:0]   ptr,
  output logic [N-1:0]          gnt,
  output logic [idx_w(N)-1:0]   gnt_idx,
  output logic                  gnt_any
);

  localparam int IW = idx_w(N);

  // Scan from the farthest candidate back to ptr so the nearest one wins.
  always_comb begin
    int cand;
    cand    = 0;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = (int'(ptr) + k) % N;
      if (req[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        gnt_idx   = IW'(cand);
        gnt_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/comm_arbiter.sv
// Round-robin arbiter sharing one UART command master among NUM_REQ
// requesters. One command in flight at a time: grant, pulse send_cmd, wait
// for cmd_sent, then wait for the response byte or a timeout, and return the
// result to the owner.
//
// Optional feature: define COMM_ARB_RETRY_EN to re-send a timed-out command
// up to MAX_RETRY times before reporting rsp_err.
module comm_arbiter
  import comm_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 2_500_000,
  parameter int MAX_RETRY   = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  comm_arbiter_if.master                  bus,
  output arb_state_t                      state_dbg,
  output logic [idx_w(MAX_RETRY+1)-1:0]   retry_dbg
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int TW = idx_w(TIMEOUT_CYC);
  localparam int RW = idx_w(MAX_RETRY + 1);

  localparam logic [TW-1:0]      TIMER_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0   = NUM_REQ'(1);

  localparam logic [1:0] ST_IDLE      = IDLE;
  localparam logic [1:0] ST_SEND      = SEND;
  localparam logic [1:0] ST_WAIT_SENT = WAIT_SENT;
  localparam logic [1:0] ST_WAIT_RESP = WAIT_RESP;

  logic [1:0]         state_q;
  logic [IW-1:0]      ptr_q;
  logic [IW-1:0]      owner_q;
  logic [7:0]         cmd_q;
  logic [15:0]        data_q;
  logic [TW-1:0]      timer_q;
  logic [NUM_REQ-1:0] rsp_vld_q;
  logic [7:0]         rsp_data_q;
  logic               rsp_err_q;

  logic [NUM_REQ-1:0] rr_gnt;
  logic [IW-1:0]      rr_idx;
  logic               rr_any;
  logic [IW-1:0]      ptr_nxt;
  logic [7:0]         cmd_sel;
  logic [15:0]        data_sel;
  logic               grant_fire;
  logic               timeout_hit;
  logic               retry_more;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req     (bus.req_vld),
    .ptr     (ptr_q),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  // Grants are only issued from IDLE; rst masks the combinational pulse.
  assign grant_fire   = (state_q == ST_IDLE) && rr_any && !rst;
  assign bus.req_gnt  = grant_fire ? rr_gnt : '0;
  assign bus.send_cmd = (state_q == ST_SEND);
  assign bus.busy     = (state_q != ST_IDLE);
  // Every resp_rdy is acknowledged, in or out of WAIT_RESP; strays are dropped.
  assign bus.clr_resp_rdy = bus.resp_rdy && !rst;
  assign bus.cmd      = cmd_q;
  assign bus.data     = data_q;
  assign bus.rsp_vld  = rsp_vld_q;
  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_err  = rsp_err_q;
  assign state_dbg    = arb_state_t'(state_q);

  assign ptr_nxt     = (rr_idx == IW'(NUM_REQ - 1)) ? '0 : rr_idx + 1'b1;
  assign timeout_hit = (timer_q == TIMER_LAST);

  // Select the winning requester's command and payload from the packed buses.
  always_comb begin
    cmd_sel  = '0;
    data_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rr_gnt[i]) begin
        cmd_sel  = bus.req_cmd[8*i +: 8];
        data_sel = bus.req_data[16*i +: 16];
      end
    end
  end

`ifdef COMM_ARB_RETRY_EN
  logic [RW-1:0] retry_q;

  assign retry_more = (retry_q < RW'(MAX_RETRY));
  assign retry_dbg  = retry_q;

  // Count re-sends of the current command; a fresh grant starts over.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retry_q <= '0;
    end else if (grant_fire) begin
      retry_q <= '0;
    end else if ((state_q == ST_WAIT_RESP) && !bus.resp_rdy && timeout_hit && retry_more) begin
      retry_q <= retry_q + 1'b1;
    end
  end
`else
  assign retry_more = 1'b0;
  assign retry_dbg  = '0;
`endif

  // Transaction FSM with pointer, latched command and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      cmd_q      <= '0;
      data_q     <= '0;
      timer_q    <= '0;
      rsp_vld_q  <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      rsp_vld_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (rr_any) begin
            owner_q <= rr_idx;
            cmd_q   <= cmd_sel;
            data_q  <= data_sel;
            ptr_q   <= ptr_nxt;
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          state_q <= ST_WAIT_SENT;
        end
        ST_WAIT_SENT: begin
          if (bus.cmd_sent) begin
            timer_q <= '0;
            state_q <= ST_WAIT_RESP;
          end
        end
        ST_WAIT_RESP: begin
          if (timer_q != '1) begin
            timer_q <= timer_q + 1'b1;
          end
          // A response arriving on the last timer cycle still counts.
          if (bus.resp_rdy) begin
            rsp_vld_q  <= ONE_HOT0 << owner_q;
            rsp_data_q <= bus.resp;
            rsp_err_q  <= 1'b0;
            state_q    <= ST_IDLE;
          end else if (timeout_hit) begin
            if (retry_more) begin
              state_q <= ST_SEND;
            end else begin
              rsp_vld_q  <= ONE_HOT0 << owner_q;
              rsp_data_q <= TIMEOUT_RSP;
              rsp_err_q  <= 1'b1;
              state_q    <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comm_arbiter.sv
// Directed bench for comm_arbiter: single transaction, round-robin order,
// timeout (with or without COMM_ARB_RETRY_EN), response/timeout race, stray
// resp_rdy, and reset in the middle of a transaction.
module tb_comm_arbiter;
  import comm_arb_pkg::*;

  localparam int NR = 4;
  localparam int T  = 100;
  localparam int MR = 2;
`ifdef COMM_ARB_RETRY_EN
  localparam int EXP_SENDS = MR + 1;
`else
  localparam int EXP_SENDS = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  arb_state_t state_dbg;
  logic [1:0] retry_dbg;

  comm_arbiter_if #(.NUM_REQ(NR)) bus ();

  comm_arbiter #(
    .NUM_REQ     (NR),
    .TIMEOUT_CYC (T),
    .MAX_RETRY   (MR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg),
    .retry_dbg (retry_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge; outputs are sampled at
  // the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [7:0] c, input logic [15:0] d);
    bus.req_cmd[8*i +: 8]   = c;
    bus.req_data[16*i +: 16] = d;
  endtask

  // ---------------- stimulus ----------------
  int         cyc;
  int         rsp_cyc;
  int         wr_start;
  int         n_send;
  logic       saw_send;
  logic [1:0] exp_idx;
  logic [1:0] prev_idx;
  logic [3:0] seen_vld;

  initial begin
    rst          = 1'b1;
    bus.req_vld  = '0;
    bus.req_cmd  = '0;
    bus.req_data = '0;
    bus.cmd_sent = 1'b0;
    bus.resp     = '0;
    bus.resp_rdy = 1'b0;
    prev_idx     = '0;

    // Reset state
    tick();
    mid();
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_send_cmd", bus.send_cmd, 0);
    check_eq("rst_rsp_vld", bus.rsp_vld, 0);
    check_eq("rst_state", 32'(state_dbg), 32'(IDLE));
    check_eq("rst_retry", retry_dbg, 0);
    tick();
    rst = 1'b0;

    // 1: single request from requester 1
    set_req(1, 8'h02, 16'h1234);
    bus.req_vld = 4'b0010;
    mid();
    check_eq("t1_gnt", bus.req_gnt, 4'b0010);
    tick();
    bus.req_vld = '0;
    mid();
    check_eq("t1_send_cmd", bus.send_cmd, 1);
    check_eq("t1_cmd", bus.cmd, 8'h02);
    check_eq("t1_data", bus.data, 16'h1234);
    check_eq("t1_busy", bus.busy, 1);
    tick();
    bus.cmd_sent = 1'b1;
    mid();
    check_eq("t1_send_once", bus.send_cmd, 0);
    tick();
    bus.cmd_sent = 1'b0;
    tick();
    bus.resp     = 8'hA5;
    bus.resp_rdy = 1'b1;
    mid();
    check_eq("t1_clr", bus.clr_resp_rdy, 1);
    check_eq("t1_no_early_rsp", bus.rsp_vld, 0);
    tick();
    bus.resp_rdy = 1'b0;
    mid();
    check_eq("t1_rsp_vld", bus.rsp_vld, 4'b0010);
    check_eq("t1_rsp_data", bus.rsp_data, 8'hA5);
    check_eq("t1_rsp_err", bus.rsp_err, 0);
    check_eq("t1_clr_once", bus.clr_resp_rdy, 0);
    check_eq("t1_idle", bus.busy, 0);
    tick();
    mid();
    check_eq("t1_rsp_pulse", bus.rsp_vld, 0);
    tick();

    // 2: fairness with all four requests held, pointer starting at 0
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 8'(8'h40 + i), 16'(16'h1000 + i));
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    bus.req_vld = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_idx = exp_q.pop_front();
      mid();
      check_eq("t2_gnt", bus.req_gnt, 4'b0001 << exp_idx);
      if (k > 0) begin
        check_eq("t2_rsp_vld", bus.rsp_vld, 4'b0001 << prev_idx);
        check_eq("t2_rsp_data", bus.rsp_data, 8'(8'h10 + k - 1));
      end
      tick();
      mid();
      check_eq("t2_cmd", bus.cmd, 8'(8'h40 + exp_idx));
      tick();
      bus.cmd_sent = 1'b1;
      tick();
      bus.cmd_sent = 1'b0;
      bus.resp     = 8'(8'h10 + k);
      bus.resp_rdy = 1'b1;
      tick();
      bus.resp_rdy = 1'b0;
      if (k == 4) bus.req_vld = '0;
      prev_idx = exp_idx;
    end
    mid();
    check_eq("t2_last_rsp", bus.rsp_vld, 4'b0001);
    check_eq("t2_last_data", bus.rsp_data, 8'h14);
    check_eq("t2_no_gnt", bus.req_gnt, 0);
    tick();

    // 3: timeout; pointer is 1 so requester 2 wins
    set_req(2, 8'h33, 16'hCAFE);
    bus.req_vld = 4'b0100;
    mid();
    check_eq("t3_gnt", bus.req_gnt, 4'b0100);
    tick();
    bus.req_vld = '0;
    rsp_cyc  = -1;
    cyc      = 0;
    n_send   = 0;
    wr_start = 0;
    while (rsp_cyc < 0 && cyc < 1000) begin
      mid();
      if (bus.send_cmd) n_send++;
      if (bus.rsp_vld != '0) begin
        rsp_cyc = cyc;
      end else begin
        saw_send = bus.send_cmd;
        tick();
        bus.cmd_sent = saw_send;
        if (saw_send) wr_start = cyc + 2;
        cyc++;
      end
    end
    check_eq("t3_rsp_seen", (rsp_cyc >= 0), 1);
    // rsp_vld rises TIMEOUT_CYC cycles after the first WAIT_RESP cycle
    check_eq("t3_latency", rsp_cyc - wr_start, T);
    check_eq("t3_sends", n_send, EXP_SENDS);
    check_eq("t3_rsp_vld", bus.rsp_vld, 4'b0100);
    check_eq("t3_rsp_err", bus.rsp_err, 1);
    check_eq("t3_rsp_data", bus.rsp_data, 8'h00);
    tick();

    // 4: response on the last timer cycle beats the timeout
    set_req(3, 8'h44, 16'h0F0F);
    bus.req_vld = 4'b1000;
    mid();
    check_eq("t4_gnt", bus.req_gnt, 4'b1000);
    tick();
    bus.req_vld = '0;
    tick();
    bus.cmd_sent = 1'b1;
    tick();
    bus.cmd_sent = 1'b0;
    repeat (T - 1) tick();
    bus.resp     = 8'h5C;
    bus.resp_rdy = 1'b1;
    mid();
    check_eq("t4_clr", bus.clr_resp_rdy, 1);
    check_eq("t4_still_busy", bus.busy, 1);
    tick();
    bus.resp_rdy = 1'b0;
    mid();
    check_eq("t4_rsp_vld", bus.rsp_vld, 4'b1000);
    check_eq("t4_rsp_err", bus.rsp_err, 0);
    check_eq("t4_rsp_data", bus.rsp_data, 8'h5C);
    tick();

    // 5: stray resp_rdy while idle
    bus.resp     = 8'hEE;
    bus.resp_rdy = 1'b1;
    mid();
    check_eq("t5_clr", bus.clr_resp_rdy, 1);
    check_eq("t5_busy", bus.busy, 0);
    tick();
    bus.resp_rdy = 1'b0;
    mid();
    check_eq("t5_no_rsp", bus.rsp_vld, 0);
    check_eq("t5_busy_after", bus.busy, 0);
    check_eq("t5_data_kept", bus.rsp_data, 8'h5C);
    check_eq("t5_state", 32'(state_dbg), 32'(IDLE));
    tick();

    // 6: reset while waiting for cmd_sent
    set_req(1, 8'h77, 16'hBEEF);
    bus.req_vld = 4'b0010;
    mid();
    check_eq("t6_gnt", bus.req_gnt, 4'b0010);
    tick();
    bus.req_vld = '0;
    tick();
    mid();
    check_eq("t6_wait_sent", 32'(state_dbg), 32'(WAIT_SENT));
    #1 rst = 1'b1;
    #1;
    check_eq("t6_busy", bus.busy, 0);
    check_eq("t6_cmd", bus.cmd, 0);
    check_eq("t6_data", bus.data, 0);
    check_eq("t6_state", 32'(state_dbg), 32'(IDLE));
    tick();
    rst      = 1'b0;
    seen_vld = '0;
    repeat (5) begin
      mid();
      seen_vld = seen_vld | bus.rsp_vld;
      tick();
    end
    check_eq("t6_no_rsp", seen_vld, 0);
    bus.req_vld = 4'b1111;
    mid();
    check_eq("t6_ptr_restart", bus.req_gnt, 4'b0001);
    tick();
    bus.req_vld = '0;
    mid();
    check_eq("t6_send_cmd", bus.send_cmd, 1);
    check_eq("t6_new_cmd", bus.cmd, 8'h40);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
